// File: rtl/apb_requester_arbiter_if.sv
// Bundles the requester-side handshake and the shared APB bus of the arbiter.
// The master modport is the arbiter's view; slave is the requesters/completers side.
interface apb_requester_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_write;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            req_grant;
  logic [NUM_REQ-1:0]            req_done;
  logic                          req_err;
  logic [DATA_WIDTH-1:0]         req_rdata;

  logic [ADDR_WIDTH-1:0]         PADDR;
  logic [1:0]                    PSEL;
  logic                          PENABLE;
  logic                          PWRITE;
  logic [DATA_WIDTH-1:0]         PWDATA;
  logic                          PREADY0;
  logic                          PREADY1;
  logic [DATA_WIDTH-1:0]         PRDATA0;
  logic [DATA_WIDTH-1:0]         PRDATA1;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_grant, req_done, req_err, req_rdata,
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    input  PREADY0, PREADY1, PRDATA0, PRDATA1
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_grant, req_done, req_err, req_rdata,
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    output PREADY0, PREADY1, PRDATA0, PRDATA1
  );
endinterface

// File: rtl/apb_requester_arbiter.sv
// Round-robin arbiter driving one APB bus for NUM_REQ requesters, with two
// completers selected by the address MSB and an optional PREADY timeout.
module apb_requester_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16,
  parameter int TIMEOUT    = 64
) (
  input  logic                           PCLK,
  input  logic                           PRESET,
  apb_requester_arbiter_if.master        bus
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int MSB   = ADDR_WIDTH - 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]        wait_q, wait_d;
  logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic                    pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
  logic [1:0]              psel_q, psel_d;
  logic                    penable_q, penable_d;
  logic [NUM_REQ-1:0]      grant_q, grant_d;
  logic [NUM_REQ-1:0]      done_q, done_d;
  logic                    err_q, err_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

  logic [NUM_REQ-1:0]      eligible;
  logic                    found;
  logic [IDX_W-1:0]        pick;
  logic [IDX_W-1:0]        cand;
  logic                    sel_ready;
  logic [DATA_WIDTH-1:0]   sel_rdata;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    wait_d    = wait_q;
    paddr_d   = paddr_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    grant_d   = grant_q;
    done_d    = '0;
    err_d     = 1'b0;
    rdata_d   = rdata_q;

    // A requester whose done is pulsing still shows its old request; mask it.
    eligible = bus.req_valid & ~done_q;
    found    = 1'b0;
    pick     = '0;
    cand     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
      if (!found && eligible[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end

    // Completer return path follows the latched address, not the live request.
    sel_ready = paddr_q[MSB] ? bus.PREADY1 : bus.PREADY0;
    sel_rdata = paddr_q[MSB] ? bus.PRDATA1 : bus.PRDATA0;

    case (state_q)
      ST_IDLE: begin
        psel_d    = '0;
        penable_d = 1'b0;
        grant_d   = '0;
        if (found) begin
          state_d  = ST_SETUP;
          ptr_d    = pick;
          idx_d    = pick;
          wait_d   = '0;
          paddr_d  = bus.req_addr[int'(pick)*ADDR_WIDTH +: ADDR_WIDTH];
          pwrite_d = bus.req_write[pick];
          pwdata_d = bus.req_wdata[int'(pick)*DATA_WIDTH +: DATA_WIDTH];
          psel_d   = bus.req_addr[int'(pick)*ADDR_WIDTH + MSB] ? 2'b10 : 2'b01;
          grant_d  = NUM_REQ'(1) << pick;
        end
      end
      ST_SETUP: begin
        penable_d = 1'b1;
        state_d   = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (sel_ready) begin
          state_d   = ST_IDLE;
          psel_d    = '0;
          penable_d = 1'b0;
          grant_d   = '0;
          done_d    = NUM_REQ'(1) << idx_q;
          if (!pwrite_q) rdata_d = sel_rdata;
        end else begin
          wait_d = wait_q + 1'b1;
          if (TIMEOUT != 0 && wait_d == CNT_W'(TIMEOUT)) begin
            state_d   = ST_IDLE;
            psel_d    = '0;
            penable_d = 1'b0;
            grant_d   = '0;
            done_d    = NUM_REQ'(1) << idx_q;
            err_d     = 1'b1;
            rdata_d   = '0;
          end
        end
      end
      default: begin
        state_d   = ST_IDLE;
        psel_d    = '0;
        penable_d = 1'b0;
        grant_d   = '0;
      end
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q   <= ST_IDLE;
      ptr_q     <= IDX_W'(NUM_REQ - 1);
      idx_q     <= '0;
      wait_q    <= '0;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      psel_q    <= '0;
      penable_q <= 1'b0;
      grant_q   <= '0;
      done_q    <= '0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      wait_q    <= wait_d;
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

  assign bus.req_grant = grant_q;
  assign bus.req_done  = done_q;
  assign bus.req_err   = err_q;
  assign bus.req_rdata = rdata_q;
  assign bus.PADDR     = paddr_q;
  assign bus.PSEL      = psel_q;
  assign bus.PENABLE   = penable_q;
  assign bus.PWRITE    = pwrite_q;
  assign bus.PWDATA    = pwdata_q;

endmodule

// File: tb/tb_apb_requester_arbiter.sv
// Directed bench for apb_requester_arbiter: two requesters, two SRAM completers,
// TIMEOUT=4 so both wait states and the abort path are reachable.
module tb_apb_requester_arbiter;

  localparam int NR = 2;
  localparam int AW = 10;
  localparam int DW = 16;

  logic PCLK;
  logic PRESET;

  apb_requester_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_if ();

  apb_requester_arbiter #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(4)
  ) dut (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .bus    (bus_if.master)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // Two small SRAM completers
  logic [DW-1:0] mem0 [0:(1<<(AW-1))-1];
  logic [DW-1:0] mem1 [0:(1<<(AW-1))-1];
  int wr0_cnt = 0;
  int wr1_cnt = 0;

  always @(posedge PCLK) begin
    if (bus_if.PENABLE && bus_if.PWRITE) begin
      if (bus_if.PSEL[0] && bus_if.PREADY0) begin
        mem0[bus_if.PADDR[AW-2:0]] <= bus_if.PWDATA;
        wr0_cnt <= wr0_cnt + 1;
      end
      if (bus_if.PSEL[1] && bus_if.PREADY1) begin
        mem1[bus_if.PADDR[AW-2:0]] <= bus_if.PWDATA;
        wr1_cnt <= wr1_cnt + 1;
      end
    end
  end

  assign bus_if.PRDATA0 = mem0[bus_if.PADDR[AW-2:0]];
  assign bus_if.PRDATA1 = mem1[bus_if.PADDR[AW-2:0]];

  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Observations captured by xfer
  logic [1:0]    t1_psel, t1_grant, done_psel;
  logic          t1_pen, t2_pen, done_pen, xerr;
  logic [DW-1:0] xrdata;
  int            lat;

  task automatic xfer(input int r, input bit wr, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input int wait_n);
    int  pen_cnt;
    bit  got;
    pen_cnt = 0;
    got     = 1'b0;
    lat     = 0;
    bus_if.req_write[r]           = wr;
    bus_if.req_addr[r*AW +: AW]   = a;
    bus_if.req_wdata[r*DW +: DW]  = d;
    bus_if.req_valid[r]           = 1'b1;
    bus_if.PREADY0 = (wait_n == 0);
    bus_if.PREADY1 = (wait_n == 0);
    for (int c = 1; c <= 30 && !got; c++) begin
      @(negedge PCLK);
      lat = c;
      if (c == 1) begin
        t1_psel  = bus_if.PSEL;
        t1_grant = bus_if.req_grant;
        t1_pen   = bus_if.PENABLE;
      end
      if (c == 2) t2_pen = bus_if.PENABLE;
      if (bus_if.req_done[r]) begin
        got       = 1'b1;
        done_psel = bus_if.PSEL;
        done_pen  = bus_if.PENABLE;
        xerr      = bus_if.req_err;
        xrdata    = bus_if.req_rdata;
        bus_if.req_valid[r] = 1'b0;
      end else if (bus_if.PENABLE) begin
        pen_cnt++;
        if (pen_cnt > wait_n) begin
          bus_if.PREADY0 = 1'b1;
          bus_if.PREADY1 = 1'b1;
        end
      end
    end
    if (!got) begin
      chk("xfer_done_seen", 32'd0, 32'd1);
      bus_if.req_valid[r] = 1'b0;
    end
    bus_if.PREADY0 = 1'b1;
    bus_if.PREADY1 = 1'b1;
    @(negedge PCLK);
  endtask

  int  order [6];
  int  n_done;
  int  done_t [3];
  int  k, setups, base_wr;
  bit  got_a, got0, got1;

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    PRESET           = 1'b1;
    bus_if.req_valid = '0;
    bus_if.req_write = '0;
    bus_if.req_addr  = '0;
    bus_if.req_wdata = '0;
    bus_if.PREADY0   = 1'b1;
    bus_if.PREADY1   = 1'b1;
    repeat (2) @(negedge PCLK);

    chk("rst_psel",    32'(bus_if.PSEL),      32'd0);
    chk("rst_penable", 32'(bus_if.PENABLE),   32'd0);
    chk("rst_grant",   32'(bus_if.req_grant), 32'd0);
    chk("rst_done",    32'(bus_if.req_done),  32'd0);
    chk("rst_rdata",   32'(bus_if.req_rdata), 32'd0);
    chk("rst_paddr",   32'(bus_if.PADDR),     32'd0);
    PRESET = 1'b0;

    // Requester 0 write then read on completer 0
    xfer(0, 1'b1, 10'h005, 16'hBEEF, 0);
    chk("w0_t1_psel",  32'(t1_psel),  32'h1);
    chk("w0_t1_grant", 32'(t1_grant), 32'h1);
    chk("w0_t1_pen",   32'(t1_pen),   32'd0);
    chk("w0_t2_pen",   32'(t2_pen),   32'd1);
    chk("w0_latency",  32'(lat),      32'd3);
    chk("w0_err",      32'(xerr),     32'd0);
    chk("w0_mem",      32'(mem0[5]),  32'hBEEF);
    xfer(0, 1'b0, 10'h005, 16'h0000, 0);
    chk("r0_latency",  32'(lat),      32'd3);
    chk("r0_rdata",    32'(xrdata),   32'hBEEF);
    chk("r0_err",      32'(xerr),     32'd0);

    // Requester 1 on completer 1; the same low address bits hold 0xBEEF in completer 0
    base_wr = wr0_cnt;
    xfer(1, 1'b1, 10'h205, 16'h1234, 0);
    chk("w1_t1_psel",  32'(t1_psel),  32'h2);
    chk("w1_t1_grant", 32'(t1_grant), 32'h2);
    chk("w1_mem1",     32'(mem1[5]),  32'h1234);
    xfer(1, 1'b0, 10'h205, 16'h0000, 0);
    chk("r1_rdata",    32'(xrdata),   32'h1234);
    chk("r1_latency",  32'(lat),      32'd3);
    chk("c0_no_write", 32'(wr0_cnt),  32'(base_wr));
    chk("c0_mem_kept", 32'(mem0[5]),  32'hBEEF);

    // Both requesters held valid: strict alternation starting with requester 0
    bus_if.req_write = 2'b00;
    bus_if.req_addr  = {10'h210, 10'h010};
    bus_if.req_valid = 2'b11;
    n_done = 0;
    for (int c = 0; c < 60 && n_done < 6; c++) begin
      @(negedge PCLK);
      if (bus_if.req_done != '0) begin
        order[n_done] = (bus_if.req_done == 2'b10) ? 1 : 0;
        n_done++;
        if (n_done == 6) bus_if.req_valid = 2'b00;
      end
    end
    bus_if.req_valid = 2'b00;
    @(negedge PCLK);
    chk("rr_count", 32'(n_done), 32'd6);
    for (int i = 0; i < 6; i++) chk($sformatf("rr_order%0d", i), 32'(order[i]), 32'(i % 2));

    // Three wait states, then a stuck PREADY hitting the 4-cycle timeout
    xfer(0, 1'b0, 10'h005, 16'h0000, 3);
    chk("ws_latency",  32'(lat),       32'd6);
    chk("ws_err",      32'(xerr),      32'd0);
    chk("ws_rdata",    32'(xrdata),    32'hBEEF);
    xfer(0, 1'b0, 10'h005, 16'h0000, 100);
    chk("to_latency",  32'(lat),       32'd6);
    chk("to_err",      32'(xerr),      32'd1);
    chk("to_rdata",    32'(xrdata),    32'd0);
    chk("to_psel",     32'(done_psel), 32'd0);
    chk("to_pen",      32'(done_pen),  32'd0);

    // Sole requester back-to-back: done cycle is masked, so done spacing is 4
    base_wr = wr0_cnt;
    k = 0;
    setups = 0;
    bus_if.req_write[0]    = 1'b1;
    bus_if.req_addr[0 +: AW]  = 10'h020;
    bus_if.req_wdata[0 +: DW] = 16'hA000;
    bus_if.req_valid[0]    = 1'b1;
    for (int c = 1; c <= 40 && k < 3; c++) begin
      @(negedge PCLK);
      if (bus_if.PSEL != 2'b00 && !bus_if.PENABLE) setups++;
      if (bus_if.req_done[0]) begin
        done_t[k] = c;
        k++;
        if (k < 3) begin
          bus_if.req_addr[0 +: AW]  = AW'(32'h20 + k);
          bus_if.req_wdata[0 +: DW] = DW'(32'hA000 + k);
        end else begin
          bus_if.req_valid[0] = 1'b0;
        end
      end
    end
    bus_if.req_valid[0] = 1'b0;
    @(negedge PCLK);
    chk("b2b_count",  32'(k),                    32'd3);
    chk("b2b_gap01",  32'(done_t[1] - done_t[0]), 32'd4);
    chk("b2b_gap12",  32'(done_t[2] - done_t[1]), 32'd4);
    chk("b2b_setups", 32'(setups),               32'd3);
    chk("b2b_writes", 32'(wr0_cnt - base_wr),    32'd3);
    chk("b2b_mem21",  32'(mem0[9'h021]),         32'hA001);
    chk("b2b_mem22",  32'(mem0[9'h022]),         32'hA002);

    // Reset during ACCESS, then both request: requester 0 must win
    bus_if.req_write[0]       = 1'b1;
    bus_if.req_addr[0 +: AW]  = 10'h030;
    bus_if.req_wdata[0 +: DW] = 16'h5555;
    bus_if.PREADY0            = 1'b0;
    bus_if.req_valid[0]       = 1'b1;
    got_a = 1'b0;
    for (int c = 0; c < 10 && !got_a; c++) begin
      @(negedge PCLK);
      if (bus_if.PENABLE) got_a = 1'b1;
    end
    chk("mr_reach_access", 32'(got_a), 32'd1);
    PRESET = 1'b1;
    @(negedge PCLK);
    chk("mr_psel",  32'(bus_if.PSEL),      32'd0);
    chk("mr_pen",   32'(bus_if.PENABLE),   32'd0);
    chk("mr_done",  32'(bus_if.req_done),  32'd0);
    chk("mr_grant", 32'(bus_if.req_grant), 32'd0);
    PRESET                  = 1'b0;
    bus_if.PREADY0          = 1'b1;
    bus_if.req_write[1]     = 1'b0;
    bus_if.req_addr[AW +: AW] = 10'h205;
    bus_if.req_valid[1]     = 1'b1;
    @(negedge PCLK);
    chk("mr_first_grant", 32'(bus_if.req_grant), 32'h1);
    got0 = 1'b0;
    got1 = 1'b0;
    for (int c = 0; c < 30 && !(got0 && got1); c++) begin
      @(negedge PCLK);
      if (bus_if.req_done[0]) begin got0 = 1'b1; bus_if.req_valid[0] = 1'b0; end
      if (bus_if.req_done[1]) begin got1 = 1'b1; bus_if.req_valid[1] = 1'b0; end
    end
    bus_if.req_valid = 2'b00;
    @(negedge PCLK);
    chk("mr_both_done", 32'({got1, got0}), 32'h3);
    chk("mr_mem30",     32'(mem0[9'h030]), 32'h5555);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
